// File: rtl/mode1_row_max.sv
// Streaming row-max reduction: folds a row of 8-lane fp16 vectors into one maximum
// using a bit-exact total ordering, then holds it until the consumer takes it.
module mode1_row_max #(
  parameter int DATAWIDTH = 16,
  parameter int EXPONENT  = 5,
  parameter int MANTISSA  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           num_vecs,
  input  logic                 in_valid,
  input  logic [DATAWIDTH-1:0] inp0,
  input  logic [DATAWIDTH-1:0] inp1,
  input  logic [DATAWIDTH-1:0] inp2,
  input  logic [DATAWIDTH-1:0] inp3,
  input  logic [DATAWIDTH-1:0] inp4,
  input  logic [DATAWIDTH-1:0] inp5,
  input  logic [DATAWIDTH-1:0] inp6,
  input  logic [DATAWIDTH-1:0] inp7,
  output logic                 in_ready,
  output logic                 max_valid,
  output logic [DATAWIDTH-1:0] max_out,
  input  logic                 max_ready,
  output logic                 busy
);

  localparam int                   SIGN      = EXPONENT + MANTISSA;
  localparam logic [DATAWIDTH-1:0] SIGN_MASK = DATAWIDTH'(1) << SIGN;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Negatives get all bits flipped, positives get only the sign flipped, so the
  // resulting key orders every bit pattern monotonically as an unsigned number.
  function automatic logic [DATAWIDTH-1:0] f_key(input logic [DATAWIDTH-1:0] x);
    return x[SIGN] ? ~x : (x ^ SIGN_MASK);
  endfunction

  function automatic logic [DATAWIDTH-1:0] f_max(input logic [DATAWIDTH-1:0] a,
                                                 input logic [DATAWIDTH-1:0] b);
    return (f_key(a) > f_key(b)) ? a : b;
  endfunction

  state_e               r_state;
  state_e               w_next_state;
  logic [7:0]           r_cnt;
  logic [DATAWIDTH-1:0] r_acc;
  logic                 r_first;

  logic [DATAWIDTH-1:0] w_lane [8];
  logic [DATAWIDTH-1:0] w_l1   [4];
  logic [DATAWIDTH-1:0] w_l2   [2];
  logic [DATAWIDTH-1:0] w_vec_max;
  logic                 w_start_ok;
  logic                 w_accept;

  always_comb begin
    w_lane[0] = inp0;
    w_lane[1] = inp1;
    w_lane[2] = inp2;
    w_lane[3] = inp3;
    w_lane[4] = inp4;
    w_lane[5] = inp5;
    w_lane[6] = inp6;
    w_lane[7] = inp7;
    for (int i = 0; i < 4; i++) w_l1[i] = f_max(w_lane[2*i], w_lane[2*i+1]);
    for (int i = 0; i < 2; i++) w_l2[i] = f_max(w_l1[2*i], w_l1[2*i+1]);
    w_vec_max = f_max(w_l2[0], w_l2[1]);
  end

  assign w_start_ok = (r_state == S_IDLE) && start && (num_vecs != 8'd0);
  assign w_accept   = (r_state == S_ACCUM) && in_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: next state defaults to the current state before any branch, so no
  // path through this block can leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_ACCUM;
      S_ACCUM: if (w_accept && (r_cnt == 8'd1)) w_next_state = S_DONE;
      S_DONE:  if (max_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_ACCUM);
    max_valid = (r_state == S_DONE);
    busy      = (r_state != S_IDLE);
    max_out   = r_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= 8'd0;
      r_acc   <= '0;
      r_first <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt   <= num_vecs;
      r_first <= 1'b1;
    end else if (w_accept) begin
      r_acc   <= r_first ? w_vec_max : f_max(r_acc, w_vec_max);
      r_first <= 1'b0;
      r_cnt   <= r_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_mode1_row_max.sv
// Directed bench for mode1_row_max: table of single-vector rows plus hand-written
// multi-cycle sequences for gaps, back-pressure, mid-row reset and zero length.
module tb_mode1_row_max;

  typedef logic [15:0] lanes_t [8];

  typedef struct {
    string       name;
    lanes_t      lanes;
    logic [15:0] exp_max;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_vecs;
  logic        in_valid;
  logic [15:0] inp [8];
  logic        in_ready;
  logic        max_valid;
  logic [15:0] max_out;
  logic        max_ready;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  vec_t   tbl [10];
  lanes_t zero_lanes = '{default: 16'h0000};

  mode1_row_max #(.DATAWIDTH(16), .EXPONENT(5), .MANTISSA(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_vecs  (num_vecs),
    .in_valid  (in_valid),
    .inp0      (inp[0]),
    .inp1      (inp[1]),
    .inp2      (inp[2]),
    .inp3      (inp[3]),
    .inp4      (inp[4]),
    .inp5      (inp[5]),
    .inp6      (inp[6]),
    .inp7      (inp[7]),
    .in_ready  (in_ready),
    .max_valid (max_valid),
    .max_out   (max_out),
    .max_ready (max_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Applies one cycle of lane stimulus at a falling edge and counts a handshake.
  task automatic drive(input logic valid, input lanes_t l);
    in_valid = valid;
    for (int i = 0; i < 8; i++) inp[i] = l[i];
    if (valid && in_ready) n_acc++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] n);
    start    = 1'b1;
    num_vecs = n;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic handshake(input string nm);
    max_ready = 1'b1;
    @(negedge clk);
    max_ready = 1'b0;
    check({nm, "_idle_busy"}, 16'(busy), 16'h0);
    check({nm, "_idle_valid"}, 16'(max_valid), 16'h0);
  endtask

  task automatic run_one(input string nm, input lanes_t l, input logic [15:0] exp);
    do_start(8'd1);
    check({nm, "_in_ready"}, 16'(in_ready), 16'h1);
    drive(1'b1, l);
    check({nm, "_max_valid"}, 16'(max_valid), 16'h1);
    check({nm, "_in_ready_low"}, 16'(in_ready), 16'h0);
    check({nm, "_max_out"}, max_out, exp);
    handshake(nm);
  endtask

  initial begin
    lanes_t v1, v2, v3;
    logic [15:0] held;

    tbl[0] = '{"basic",  '{16'h3C00, 16'hC000, 16'h4400, 16'h3800, 16'h0000, 16'hBC00, 16'h4000, 16'h3E00}, 16'h4400};
    tbl[1] = '{"allneg", '{16'hC000, 16'hBC00, 16'hB800, 16'hBE00, 16'hC200, 16'hBA00, 16'hC100, 16'hB900}, 16'hB800};
    tbl[2] = '{"negzero",'{16'h8000, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00}, 16'h8000};
    tbl[3] = '{"zeros",  '{16'hFC00, 16'h8000, 16'hFC00, 16'h0000, 16'h8000, 16'hFC00, 16'hFC00, 16'hFC00}, 16'h0000};
    tbl[4] = '{"posinf", '{16'h7BFF, 16'h3C00, 16'h7C00, 16'h0000, 16'hFC00, 16'h5000, 16'h7A00, 16'h0001}, 16'h7C00};
    tbl[5] = '{"posnan", '{16'h7C00, 16'h7E00, 16'h0000, 16'h3C00, 16'hFE00, 16'h7BFF, 16'h8000, 16'hFC00}, 16'h7E00};
    tbl[6] = '{"negnan", '{16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00, 16'hFC00, 16'hFE00, 16'hFE00}, 16'hFC00};
    tbl[7] = '{"subnorm",'{16'h0001, 16'h0000, 16'h8001, 16'h03FF, 16'h8000, 16'h8000, 16'h8000, 16'h8000}, 16'h03FF};
    tbl[8] = '{"lane7",  '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3C00}, 16'h3C00};
    tbl[9] = '{"same",   '{default: 16'h5555}, 16'h5555};

    reset = 1'b1; start = 1'b0; num_vecs = 8'd0; in_valid = 1'b0; max_ready = 1'b0;
    for (int i = 0; i < 8; i++) inp[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 16'(in_ready), 16'h0);
    check("rst_max_valid", 16'(max_valid), 16'h0);
    check("rst_max_out", max_out, 16'h0000);
    check("rst_busy", 16'(busy), 16'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 10; t++) run_one(tbl[t].name, tbl[t].lanes, tbl[t].exp_max);

    // Three-vector negative row with idle gaps; the middle vector holds the max.
    v1 = '{16'hC000, 16'hBC00, 16'hBA00, 16'hC100, 16'hC000, 16'hBE00, 16'hBC00, 16'hC000};
    v2 = '{16'hBC00, 16'hB800, 16'hC000, 16'hBE00, 16'hBA00, 16'hC000, 16'hBC00, 16'hBC00};
    v3 = '{16'hBC00, 16'hBE00, 16'hC000, 16'hC000, 16'hBC00, 16'hC100, 16'hBE00, 16'hC000};
    n_acc = 0;
    do_start(8'd3);
    check("gap_busy", 16'(busy), 16'h1);
    drive(1'b1, v1);
    drive(1'b0, zero_lanes);
    check("gap_ready_in_gap", 16'(in_ready), 16'h1);
    drive(1'b1, v2);
    drive(1'b0, v1);
    check("gap_no_early_valid", 16'(max_valid), 16'h0);
    drive(1'b1, v3);
    check("gap_accepts", 16'(n_acc), 16'd3);
    check("gap_max_valid", 16'(max_valid), 16'h1);
    check("gap_max_out", max_out, 16'hB800);
    handshake("gap");

    // Cross-vector signed zero, then an infinity that must survive a later vector.
    v1 = '{16'h8000, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
    v2 = '{16'hFC00, 16'hFC00, 16'hFC00, 16'h0000, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
    do_start(8'd2);
    drive(1'b1, v1);
    drive(1'b1, v2);
    check("szero_max_out", max_out, 16'h0000);
    handshake("szero");
    v1[4] = 16'h7C00;
    do_start(8'd2);
    drive(1'b1, v1);
    drive(1'b1, v2);
    check("inf_max_out", max_out, 16'h7C00);

    // Back-pressure in DONE with a stray start that must be ignored.
    held = max_out;
    for (int c = 0; c < 5; c++) begin
      start    = (c == 2);
      num_vecs = 8'd2;
      @(negedge clk);
      check("bp_valid_hold", 16'(max_valid), 16'h1);
      check("bp_out_hold", max_out, held);
    end
    start = 1'b0;
    handshake("bp");
    run_one("bp_next", '{default: 16'h3C00}, 16'h3C00);

    // Asynchronous reset between clock edges after two of four accepts.
    n_acc = 0;
    do_start(8'd4);
    drive(1'b1, '{default: 16'h7000});
    drive(1'b1, '{default: 16'h6000});
    check("mid_accepts", 16'(n_acc), 16'd2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 16'(in_ready), 16'h0);
    check("mid_rst_busy", 16'(busy), 16'h0);
    check("mid_rst_valid", 16'(max_valid), 16'h0);
    check("mid_rst_out", max_out, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_one("post_rst", '{default: 16'h3C00}, 16'h3C00);

    // Zero-length request never leaves IDLE.
    do_start(8'd0);
    for (int c = 0; c < 4; c++) begin
      check("zero_busy", 16'(busy), 16'h0);
      check("zero_in_ready", 16'(in_ready), 16'h0);
      check("zero_valid", 16'(max_valid), 16'h0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
